triangle_sequencer: RTL and testbench

TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

---
 rtl/triangle_sequencer_pkg.sv | 29 ++
 rtl/triangle_sequencer_tri_addr_gen.sv | 26 ++
 rtl/triangle_sequencer.sv | 160 ++++++++++++++++
 tb/tb_triangle_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_sequencer_pkg.sv
// Shared definitions for the triangle sequencer.
// Holds the axis numbering used inside a vertex, the per-triangle word
// geometry, default sizing parameters and the controller state encoding.
package triangle_sequencer_pkg;

  // Axis offsets within one vertex (word = vert*3 + axis).
  localparam int AXIS_X = 0;
  localparam int AXIS_Y = 1;
  localparam int AXIS_Z = 2;

  localparam int VERTS_PER_TRI = 3;
  localparam int WORDS_PER_TRI = 9;

  localparam int DEFAULT_MAX_TRIANGLES = 4;
  localparam int DEFAULT_COORD_W       = 32;

  // Word counter inside one triangle: 0..8 fits in four bits.
  localparam int WORD_W = 4;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_TRI - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/triangle_sequencer_tri_addr_gen.sv
// tri_addr_gen: world memory word address for one coordinate.
//   tri_num : triangle number within the world
//   word    : word within the triangle (vert*3 + axis), 0..8
//   addr    : tri_num*9 + word
// The multiply by nine is a shift plus an add. The largest address is
// MAX_TRIANGLES*9-1, which by construction fits ADDR_W, so no carry out of
// ADDR_W is ever lost.
module tri_addr_gen
  import triangle_sequencer_pkg::*;
#(
  parameter int CNT_W  = 3,
  parameter int ADDR_W = 6
) (
  input  logic [CNT_W-1:0]  tri_num,
  input  logic [WORD_W-1:0] word,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] tri_ext;
  logic [ADDR_W-1:0] word_ext;

  assign tri_ext  = ADDR_W'(tri_num);
  assign word_ext = ADDR_W'(word);
  assign addr     = (tri_ext << 3) + tri_ext + word_ext;

endmodule

// File: rtl/triangle_sequencer.sv
// triangle_sequencer: streams triangles out of an external world memory.
// On start, fetches min(num_tri, MAX_TRIANGLES) triangles, nine words each,
// and presents each one on a valid/ready output before fetching the next.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   start      : pulse that begins a frame (ignored while busy)
//   num_tri    : triangles in the frame, sampled with start
//   busy       : frame in progress (FETCH/WAIT/EMIT/DONE)
//   done       : one-cycle pulse at frame end
//   mem_rd     : memory read strobe; mem_addr is the word address
//   mem_data   : read data, valid one cycle after mem_rd
//   tri_valid  : triangle present on tri_data / tri_index
//   tri_ready  : downstream accept
//   tri_data   : nine coordinates, slot (v*3+a) at [(v*3+a)*COORD_W +: COORD_W]
//   tri_index  : index of the presented triangle
//
// Handshake: a triangle transfers on a rising edge where tri_valid and
// tri_ready are both high. Once tri_valid rises it, tri_data and tri_index
// hold until that transfer; tri_valid never depends on tri_ready, and
// tri_ready has no effect while tri_valid is low.
module triangle_sequencer
  import triangle_sequencer_pkg::*;
#(
  parameter  int MAX_TRIANGLES = DEFAULT_MAX_TRIANGLES,
  parameter  int COORD_W       = DEFAULT_COORD_W,
  localparam int ADDR_W        = $clog2(MAX_TRIANGLES * WORDS_PER_TRI),
  localparam int CNT_W         = $clog2(MAX_TRIANGLES + 1),
  localparam int IDX_W         = (CNT_W > 1) ? CNT_W - 1 : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           num_tri,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [COORD_W-1:0]         mem_data,
  output logic                       tri_valid,
  input  logic                       tri_ready,
  output logic [9*COORD_W-1:0]       tri_data,
  output logic [IDX_W-1:0]           tri_index
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIANGLES);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   tri_cnt;
  logic [CNT_W-1:0]   count;
  logic [WORD_W-1:0]  word;
  logic [CNT_W-1:0]   eff_count;
  logic               last_tri;
  logic [ADDR_W-1:0]  addr_raw;

  // Requests beyond the world capacity are clamped rather than rejected.
  assign eff_count = (num_tri > MAX_CNT) ? MAX_CNT : num_tri;
  assign last_tri  = (tri_cnt == count - CNT_W'(1));

  tri_addr_gen #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .tri_num (tri_cnt),
    .word    (word),
    .addr    (addr_raw)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (eff_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (word == LAST_WORD) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        state_next = S_EMIT;
      end
      S_EMIT: begin
        if (tri_ready) begin
          state_next = last_tri ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_rd    = (state == S_FETCH);
    tri_valid = (state == S_EMIT);
    mem_addr  = mem_rd ? addr_raw : '0;
  end

  // Counters and capture register. Read data lags its strobe by one cycle,
  // so while fetching word w the bus carries word w-1; the final word lands
  // during WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_cnt   <= '0;
      count     <= '0;
      word      <= '0;
      tri_data  <= '0;
      tri_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count   <= eff_count;
            tri_cnt <= '0;
            word    <= '0;
          end
        end
        S_FETCH: begin
          if (word != '0) begin
            tri_data[(int'(word) - 1) * COORD_W +: COORD_W] <= mem_data;
          end
          word <= (word == LAST_WORD) ? '0 : word + WORD_W'(1);
        end
        S_WAIT: begin
          tri_data[int'(LAST_WORD) * COORD_W +: COORD_W] <= mem_data;
          tri_index <= IDX_W'(tri_cnt);
        end
        S_EMIT: begin
          if (tri_ready && !last_tri) begin
            tri_cnt <= tri_cnt + CNT_W'(1);
            word    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Bench for triangle_sequencer: a word-addressed memory model, a frame
// model that lists the addresses and triangles a frame must produce, and a
// monitor that compares the DUT against that model every cycle.
module tb_triangle_sequencer;

  localparam int MAXT  = 4;
  localparam int CW    = 32;
  localparam int AW    = 6;
  localparam int NW    = 3;
  localparam int IW    = 2;
  localparam int WORDS = MAXT * 9;
  localparam int DW    = 9 * CW;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NW-1:0]  num_tri;
  logic           busy;
  logic           done;
  logic           mem_rd;
  logic [AW-1:0]  mem_addr;
  logic [CW-1:0]  mem_data;
  logic           tri_valid;
  logic           tri_ready;
  logic [DW-1:0]  tri_data;
  logic [IW-1:0]  tri_index;

  triangle_sequencer #(.MAX_TRIANGLES(MAXT), .COORD_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_tri   (num_tri),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_data  (tri_data),
    .tri_index (tri_index)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [CW-1:0] mem [WORDS];
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] exp_tri_q[$];
  logic [IW-1:0] exp_idx_q[$];
  int exp_done = 0;

  bit mon_en = 1'b0;
  int n_rd = 0, n_valid = 0, n_hs = 0, n_done = 0;
  int first_rd, last_rd, first_valid, hs_cyc, done_cyc;
  logic [AW-1:0] first_addr;
  logic [DW-1:0] first_data;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Frame model: what a frame of n requested triangles must produce.
  task automatic expect_frame(input int n);
    int eff;
    logic [DW-1:0] t;
    eff = (n > MAXT) ? MAXT : n;
    for (int i = 0; i < eff; i++) begin
      t = '0;
      for (int w = 0; w < 9; w++) begin
        exp_q.push_back(AW'(i * 9 + w));
        t[w*CW +: CW] = mem[i * 9 + w];
      end
      exp_tri_q.push_back(t);
      exp_idx_q.push_back(IW'(i));
    end
    exp_done++;
  endtask

  task automatic arm();
    first_rd = -1; last_rd = -1; first_valid = -1; hs_cyc = -1; done_cyc = -1;
    first_addr = '1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd) begin
        n_rd++;
        if (first_rd < 0) begin
          first_rd = cyc;
          first_addr = mem_addr;
        end
        last_rd = cyc;
        if (exp_q.size() == 0) flag("unexpected_rd", $sformatf("addr %0d", mem_addr));
        else check("mem_addr", mem_addr, exp_q.pop_front());
      end else begin
        check("mem_addr_idle", mem_addr, 0);
      end
      check("rd_valid_excl", mem_rd & tri_valid, 0);
      if (mem_rd | tri_valid | done) check("busy", busy, 1);
      if (tri_valid) begin
        n_valid++;
        if (first_valid < 0) begin
          first_valid = cyc;
          first_data = tri_data;
        end
        if (exp_tri_q.size() == 0) begin
          flag("unexpected_valid", $sformatf("index %0d", tri_index));
        end else begin
          check("tri_data", tri_data, exp_tri_q[0]);
          check("tri_index", tri_index, exp_idx_q[0]);
          if (tri_ready) begin
            void'(exp_tri_q.pop_front());
            void'(exp_idx_q.pop_front());
            n_hs++;
            hs_cyc = cyc;
          end
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (exp_done == 0) flag("unexpected_done", $sformatf("cycle %0d", cyc));
        else begin
          exp_done--;
          check("done_tris_left", exp_tri_q.size(), 0);
          check("done_addrs_left", exp_q.size(), 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns k = cycle number of the edge that sampled start.
  task automatic do_start(input int n, output int k);
    int nv;
    arm();
    expect_frame(n);
    nv = n;
    start = 1'b1;
    num_tri = nv[NW-1:0];
    tick(1);
    start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int budget);
    int d0, i;
    d0 = n_done;
    i = 0;
    while (n_done == d0 && i < budget) begin
      tick(1);
      i++;
    end
    if (n_done == d0) flag("timeout_done", $sformatf("no done within %0d cycles", budget));
  endtask

  // ---------------- directed tests ----------------
  logic [DW-1:0] tri0_lit;
  logic [DW-1:0] hold_data;

  initial begin
    int k, k2, hs0, rd0, dn0, v0, i;

    for (int a = 0; a < WORDS; a++) mem[a] = CW'(1000 + a * 7);
    mem[0] = 100; mem[1] = 100; mem[2] = 100;
    mem[3] = 200; mem[4] = 100; mem[5] = 100;
    mem[6] = 100; mem[7] = 200; mem[8] = 100;
    tri0_lit = {32'd100, 32'd200, 32'd100, 32'd100, 32'd100, 32'd200,
                32'd100, 32'd100, 32'd100};

    rst = 1'b1; start = 1'b0; num_tri = '0; tri_ready = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_valid", tri_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", tri_data, 0);
    check("rst_index", tri_index, 0);
    mon_en = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // One triangle, ready held high: latency and literal contents.
    tri_ready = 1'b1;
    hs0 = n_hs;
    do_start(1, k);
    wait_done(40);
    check("t1_first_rd", first_rd, k);
    check("t1_last_rd", last_rd, k + 8);
    check("t1_first_addr", first_addr, 0);
    check("t1_first_valid", first_valid, k + 10);
    check("t1_data_literal", first_data, tri0_lit);
    check("t1_slot3_is_200", first_data[3*CW +: CW], 200);
    check("t1_done_after_hs", done_cyc, hs_cyc + 1);
    check("t1_done_cycle", done_cyc, k + 11);
    check("t1_handshakes", n_hs - hs0, 1);
    tick(2);

    // Four triangles back to back.
    hs0 = n_hs; rd0 = n_rd; dn0 = n_done;
    do_start(4, k);
    wait_done(80);
    check("t2_handshakes", n_hs - hs0, 4);
    check("t2_reads", n_rd - rd0, 36);
    check("t2_dones", n_done - dn0, 1);
    check("t2_last_rd", last_rd, k + 3 * 11 + 8);
    tick(1);

    // Two triangles with downstream stalled for five cycles.
    tri_ready = 1'b0;
    hs0 = n_hs; rd0 = n_rd;
    do_start(2, k);
    i = 0;
    while (!tri_valid && i < 30) begin
      tick(1);
      i++;
    end
    check("t3_valid_seen", tri_valid, 1);
    hold_data = tri_data;
    rd0 = n_rd;
    tick(5);
    check("t3_valid_held", tri_valid, 1);
    check("t3_data_held", tri_data, hold_data);
    check("t3_no_rd_stall", n_rd - rd0, 0);
    check("t3_no_hs_stall", n_hs - hs0, 0);
    tri_ready = 1'b1;
    tick(1);
    check("t3_fetch_resumes", mem_rd, 1);
    check("t3_second_addr", mem_addr, 9);
    wait_done(40);
    check("t3_handshakes", n_hs - hs0, 2);
    tick(1);

    // Zero triangles: straight to done.
    rd0 = n_rd; v0 = n_valid;
    do_start(0, k);
    wait_done(10);
    check("t4_done_cycle", done_cyc, k);
    check("t4_no_reads", n_rd - rd0, 0);
    check("t4_no_valid", n_valid - v0, 0);

    // Seven requested: clamped to four.
    hs0 = n_hs;
    do_start(7, k);
    wait_done(80);
    check("t4_clamped", n_hs - hs0, 4);
    tick(1);

    // Second start during FETCH is ignored.
    hs0 = n_hs; dn0 = n_done;
    do_start(1, k);
    tick(3);
    start = 1'b1;
    num_tri = 3'd3;
    tick(1);
    start = 1'b0;
    wait_done(40);
    tick(3);
    check("t5_handshakes", n_hs - hs0, 1);
    check("t5_dones", n_done - dn0, 1);
    check("t5_idle_after", busy, 0);

    // Reset during triangle 2's fetch abandons the frame.
    hs0 = n_hs;
    do_start(4, k);
    i = 0;
    while (!(n_hs - hs0 == 2 && mem_rd) && i < 60) begin
      tick(1);
      i++;
    end
    check("t6_in_fetch_2", mem_addr, 18);
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_mem_rd", mem_rd, 0);
    check("t6_valid", tri_valid, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_data", tri_data, 0);
    check("t6_index", tri_index, 0);
    exp_q.delete();
    exp_tri_q.delete();
    exp_idx_q.delete();
    exp_done = 0;
    dn0 = n_done;
    tick(3);
    check("t6_no_done", n_done - dn0, 0);
    rst = 1'b0;
    hs0 = n_hs;
    do_start(1, k2);
    wait_done(40);
    check("t6_restart_rd", first_rd, k2);
    check("t6_restart_addr0", first_addr, 0);
    check("t6_restart_hs", n_hs - hs0, 1);
    tick(2);

    check("final_exp_empty", exp_q.size() + exp_tri_q.size() + exp_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
